// File: rtl/surf_cout_lane_aligner.sv
// Multi-lane COUT frame aligner. Each lane collects nibbles into frames,
// optionally captures one frame, checks frames against the training word,
// and searches for frame alignment by rotating its boundary or requesting
// a PHY bitslip.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no alignment run since reset
// S_WAIT  | discarding two frame ends after a restart or boundary move
// S_CHECK | comparing frames, counting consecutive good frames
// S_SLIP  | one-cycle bitslip request to the PHY
// S_DONE  | lane locked
// S_FAIL  | bitslip budget exhausted without lock
module surf_cout_lane_aligner #(
  parameter int                          NLANES        = 1,
  parameter int                          FRAME_LEN     = 8,
  parameter logic [4*FRAME_LEN-1:0]      TRAIN_PATTERN = 32'hA55A6996,
  parameter int                          GOOD_FRAMES   = 4,
  parameter int                          MAX_SLIP      = 3,
  parameter int                          ERR_W         = 16
) (
  input  logic                            sysclk_i,
  input  logic                            rst_i,
  input  logic                            sync_i,
  input  logic [4*NLANES-1:0]             cout_i,
  input  logic                            capture_i,
  input  logic                            enable_i,
  input  logic                            align_start_i,
  output logic [4*FRAME_LEN*NLANES-1:0]   cout_parallel_o,
  output logic [NLANES-1:0]               cout_valid_o,
  output logic [NLANES-1:0]               biterr_o,
  output logic [ERR_W*NLANES-1:0]         errcnt_o,
  output logic [NLANES-1:0]               bitslip_o,
  output logic [NLANES-1:0]               aligned_o,
  output logic [NLANES-1:0]               align_fail_o,
  output logic                            busy_o
);

  localparam int W  = 4 * FRAME_LEN;
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int SW = $clog2(MAX_SLIP + 1);
  localparam int GW = $clog2(GOOD_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_CHECK, S_SLIP, S_DONE, S_FAIL
  } state_t;

  function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int n);
    return (v >> n) | (v << (W - n));
  endfunction

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NLANES-1:0] busy_lane;

  // Shared frame counter, restarted by sync
  always_comb begin
    cnt_d = sync_i ? '0 : cnt_q + CW'(1);
  end

  // Frame counter register
  always_ff @(posedge sysclk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    state_t           state_q, state_d;
    logic [CW-1:0]    off_q, off_d;
    logic [W-5:0]     sr_q, sr_d;
    logic             armed_q, armed_d;
    logic [W-1:0]     par_q, par_d;
    logic             valid_q, valid_d;
    logic             biterr_q, biterr_d;
    logic [ERR_W-1:0] errcnt_q, errcnt_d;
    logic [SW-1:0]    slipcnt_q, slipcnt_d;
    logic [GW-1:0]    goodcnt_q, goodcnt_d;
    logic             waitcnt_q, waitcnt_d;

    logic [3:0]       nib;
    logic [W-1:0]     word;
    logic             fe, mism, rot_hit;
    logic [CW-1:0]    rot_k;
    logic [GW-1:0]    good_nxt;

    assign nib      = cout_i[4*l +: 4];
    assign word     = {sr_q, nib};
    // Frame end sits one count before the lane's offset so the frame starts at cnt == off
    assign fe       = (cnt_q == off_q - CW'(1));
    assign mism     = (word != TRAIN_PATTERN);
    assign good_nxt = goodcnt_q + GW'(1);

    // Find which nibble rotation of the training word the lane is showing
    always_comb begin
      rot_hit = 1'b0;
      rot_k   = '0;
      for (int k = 1; k < FRAME_LEN; k++) begin
        if (word == rotr(TRAIN_PATTERN, 4 * k)) begin
          rot_hit = 1'b1;
          rot_k   = CW'(k);
        end
      end
    end

    // Next-state logic for assembly, capture, checking and alignment search
    always_comb begin
      sr_d      = word[W-5:0];
      armed_d   = armed_q;
      par_d     = par_q;
      valid_d   = 1'b0;
      biterr_d  = 1'b0;
      errcnt_d  = errcnt_q;
      state_d   = state_q;
      off_d     = off_q;
      slipcnt_d = slipcnt_q;
      goodcnt_d = goodcnt_q;
      waitcnt_d = waitcnt_q;

      if (fe && armed_q) begin
        par_d   = word;
        valid_d = 1'b1;
        armed_d = 1'b0;
      end else if (capture_i) begin
        armed_d = 1'b1;
      end

      // A restart swallows a coincident frame end, including its error check
      if (align_start_i) begin
        errcnt_d = '0;
      end else if (fe && (enable_i || state_q == S_CHECK) && mism) begin
        biterr_d = 1'b1;
        if (errcnt_q != '1) errcnt_d = errcnt_q + ERR_W'(1);
      end

      if (align_start_i) begin
        state_d   = S_WAIT;
        slipcnt_d = '0;
        goodcnt_d = '0;
        waitcnt_d = 1'b0;
      end else begin
        case (state_q)
          S_WAIT: begin
            if (fe) begin
              if (waitcnt_q) begin
                state_d   = S_CHECK;
                waitcnt_d = 1'b0;
              end else begin
                waitcnt_d = 1'b1;
              end
            end
          end
          S_CHECK: begin
            if (sync_i) begin
              goodcnt_d = '0;
              waitcnt_d = 1'b0;
              state_d   = S_WAIT;
            end else if (fe) begin
              if (!mism) begin
                goodcnt_d = good_nxt;
                if (good_nxt == GW'(GOOD_FRAMES)) state_d = S_DONE;
              end else if (rot_hit) begin
                off_d     = off_q + rot_k;
                goodcnt_d = '0;
                waitcnt_d = 1'b0;
                state_d   = S_WAIT;
              end else if (slipcnt_q < SW'(MAX_SLIP)) begin
                state_d = S_SLIP;
              end else begin
                state_d = S_FAIL;
              end
            end
          end
          S_SLIP: begin
            slipcnt_d = slipcnt_q + SW'(1);
            goodcnt_d = '0;
            waitcnt_d = 1'b0;
            state_d   = S_WAIT;
          end
          default: ;
        endcase
      end
    end

    // Lane registers
    always_ff @(posedge sysclk_i) begin
      if (rst_i) begin
        state_q   <= S_IDLE;
        off_q     <= '0;
        sr_q      <= '0;
        armed_q   <= 1'b0;
        par_q     <= '0;
        valid_q   <= 1'b0;
        biterr_q  <= 1'b0;
        errcnt_q  <= '0;
        slipcnt_q <= '0;
        goodcnt_q <= '0;
        waitcnt_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        off_q     <= off_d;
        sr_q      <= sr_d;
        armed_q   <= armed_d;
        par_q     <= par_d;
        valid_q   <= valid_d;
        biterr_q  <= biterr_d;
        errcnt_q  <= errcnt_d;
        slipcnt_q <= slipcnt_d;
        goodcnt_q <= goodcnt_d;
        waitcnt_q <= waitcnt_d;
      end
    end

    assign cout_parallel_o[W*l +: W]     = par_q;
    assign cout_valid_o[l]               = valid_q;
    assign biterr_o[l]                   = biterr_q;
    assign errcnt_o[ERR_W*l +: ERR_W]    = errcnt_q;
    assign bitslip_o[l]                  = (state_q == S_SLIP);
    assign aligned_o[l]                  = (state_q == S_DONE);
    assign align_fail_o[l]               = (state_q == S_FAIL);
    assign busy_lane[l]                  = (state_q == S_WAIT) || (state_q == S_CHECK) ||
                                           (state_q == S_SLIP);
  end

  assign busy_o = |busy_lane;

endmodule

// File: tb/tb_surf_cout_lane_aligner.sv
// Directed bench for surf_cout_lane_aligner with two lanes and a 4-bit error
// counter. A small PHY model turns a repeating training bitstream into
// nibbles, honours bitslip requests by skipping one bit, and restarts its
// phase on every sync pulse.
module tb_surf_cout_lane_aligner;

  localparam int NL = 2;
  localparam int EW = 4;
  localparam logic [31:0] PAT = 32'hA55A6996;

  logic               sysclk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               sync_i = 1'b0;
  logic [4*NL-1:0]    cout_i = '0;
  logic               capture_i = 1'b0;
  logic               enable_i = 1'b0;
  logic               align_start_i = 1'b0;
  logic [32*NL-1:0]   cout_parallel_o;
  logic [NL-1:0]      cout_valid_o;
  logic [NL-1:0]      biterr_o;
  logic [EW*NL-1:0]   errcnt_o;
  logic [NL-1:0]      bitslip_o;
  logic [NL-1:0]      aligned_o;
  logic [NL-1:0]      align_fail_o;
  logic               busy_o;

  surf_cout_lane_aligner #(
    .NLANES(NL), .FRAME_LEN(8), .TRAIN_PATTERN(PAT),
    .GOOD_FRAMES(4), .MAX_SLIP(3), .ERR_W(EW)
  ) dut (
    .sysclk_i(sysclk_i), .rst_i(rst_i), .sync_i(sync_i), .cout_i(cout_i),
    .capture_i(capture_i), .enable_i(enable_i), .align_start_i(align_start_i),
    .cout_parallel_o(cout_parallel_o), .cout_valid_o(cout_valid_o),
    .biterr_o(biterr_o), .errcnt_o(errcnt_o), .bitslip_o(bitslip_o),
    .aligned_o(aligned_o), .align_fail_o(align_fail_o), .busy_o(busy_o)
  );

  always #5 sysclk_i = ~sysclk_i;

  int errors = 0;
  int checks = 0;
  int bitpos[NL];
  int base[NL];
  int mode[NL];      // 0: training stream, 1: constant zero
  int slips[NL];
  int valids[NL];
  int biterrs[NL];
  logic [31:0] last_par[NL];
  int t0, t1;

  function automatic logic [3:0] gen_nib(input int bp);
    logic [31:0] pv;
    logic [3:0]  n;
    pv = PAT;
    for (int i = 0; i < 4; i++) n[3-i] = pv[31 - ((bp + i) % 32)];
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge, then drive the next nibble.
  task automatic step();
    @(posedge sysclk_i);
    #1;
    for (int l = 0; l < NL; l++) begin
      if (bitslip_o[l]) begin
        slips[l]++;
        bitpos[l] = (bitpos[l] + 1) % 32;
      end
      if (cout_valid_o[l]) begin
        valids[l]++;
        last_par[l] = cout_parallel_o[32*l +: 32];
      end
      if (biterr_o[l]) biterrs[l]++;
      if (sync_i) bitpos[l] = base[l];
      cout_i[4*l +: 4] = (mode[l] == 1) ? 4'h0 : gen_nib(bitpos[l]);
      bitpos[l] = (bitpos[l] + 4) % 32;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    for (int l = 0; l < NL; l++) begin
      slips[l] = 0; valids[l] = 0; biterrs[l] = 0; last_par[l] = '0;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    run(2);
    rst_i = 1'b0;
    clear_counts();
  endtask

  task automatic do_sync();
    sync_i = 1'b1; step(); sync_i = 1'b0;
  endtask

  task automatic do_align();
    align_start_i = 1'b1; step(); align_start_i = 1'b0;
  endtask

  task automatic do_capture();
    capture_i = 1'b1; step(); capture_i = 1'b0;
  endtask

  initial begin
    for (int l = 0; l < NL; l++) begin
      bitpos[l] = 0; base[l] = 0; mode[l] = 0;
    end
    clear_counts();

    // Reset state
    run(3);
    chk("rst_par",   cout_parallel_o, 64'h0);
    chk("rst_flags", {cout_valid_o, biterr_o, bitslip_o, aligned_o, align_fail_o, busy_o}, 64'h0);
    chk("rst_err",   errcnt_o, 64'h0);
    rst_i = 1'b0;

    // One-shot capture on an aligned stream
    do_reset();
    do_sync();
    run(16);
    clear_counts();
    do_capture();
    run(20);
    chk("cap_valid0", valids[0], 1);
    chk("cap_valid1", valids[1], 1);
    chk("cap_par0",   last_par[0], PAT);
    chk("cap_par1",   last_par[1], PAT);
    chk("cap_err",    errcnt_o, 64'h0);

    // Lane 1 delayed by 3 nibbles: fixed by boundary rotation, no bitslip
    do_reset();
    base[1] = 20;
    do_sync();
    run(16);
    clear_counts();
    do_align();
    t0 = -1;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (aligned_o[0] && t0 < 0) t0 = k;
      if (aligned_o == 2'b11) break;
    end
    chk("rot_lock_time0", t0, 47);
    chk("rot_aligned",    aligned_o, 2'b11);
    chk("rot_slips1",     slips[1], 0);
    chk("rot_slips0",     slips[0], 0);
    clear_counts();
    do_capture();
    run(20);
    chk("rot_par1",       last_par[1], PAT);
    base[1] = 0;

    // Lane 0 shifted by 2 bits: two bitslips, then a nibble rotation
    do_reset();
    base[0] = 2;
    do_sync();
    run(16);
    clear_counts();
    do_align();
    for (int k = 1; k <= 400; k++) begin
      step();
      if (aligned_o[0]) break;
    end
    chk("slip_count",   slips[0], 2);
    chk("slip_aligned", aligned_o[0], 1'b1);
    chk("slip_nofail",  align_fail_o[0], 1'b0);
    base[0] = 0;

    // Constant zero input: three bitslips, then give up
    do_reset();
    mode[0] = 1; mode[1] = 1;
    do_sync();
    run(16);
    clear_counts();
    do_align();
    t0 = -1; t1 = -1;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (bitslip_o[0] && t0 < 0) t0 = k;
      if (align_fail_o == 2'b11) begin t1 = k; break; end
    end
    chk("exh_first_slip", t0, 23);
    chk("exh_fail_time",  t1, 95);
    chk("exh_slips0",     slips[0], 3);
    chk("exh_slips1",     slips[1], 3);
    chk("exh_fail",       align_fail_o, 2'b11);
    chk("exh_aligned",    aligned_o, 2'b00);
    chk("exh_busy",       busy_o, 1'b0);

    // Error counter: clean stream first, then 20 bad frames saturating at F
    do_reset();
    mode[0] = 0; mode[1] = 0;
    do_sync();
    run(16);
    clear_counts();
    enable_i = 1'b1;
    run(40);
    enable_i = 1'b0;
    run(2);
    chk("err_clean_cnt",  biterrs[0] + biterrs[1], 0);
    chk("err_clean_reg",  errcnt_o, 64'h0);
    mode[0] = 1; mode[1] = 1;
    run(16);
    clear_counts();
    enable_i = 1'b1;
    run(160);
    enable_i = 1'b0;
    run(4);
    chk("err_pulses0", biterrs[0], 20);
    chk("err_pulses1", biterrs[1], 20);
    chk("err_sat",     errcnt_o, 8'hFF);
    do_align();
    chk("err_clear",   errcnt_o, 64'h0);

    // Reset while a lane sits in SLIP
    do_reset();
    mode[0] = 1; mode[1] = 1;
    do_sync();
    run(16);
    do_align();
    t0 = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (bitslip_o[0]) begin t0 = 1; break; end
    end
    chk("rstslip_seen", t0, 1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rstslip_flags", {cout_valid_o, biterr_o, bitslip_o, aligned_o, align_fail_o, busy_o}, 64'h0);
    chk("rstslip_err",   errcnt_o, 64'h0);
    chk("rstslip_par",   cout_parallel_o, 64'h0);
    clear_counts();
    run(150);
    chk("rstslip_noslip", slips[0] + slips[1], 0);
    chk("rstslip_idle",   busy_o, 1'b0);
    mode[0] = 0; mode[1] = 0;

    // align_start on a frame-end edge: that frame is not discarded by WAIT
    do_reset();
    do_sync();
    run(23);
    do_align();
    t0 = -1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (aligned_o[0]) begin t0 = k; break; end
    end
    chk("start_on_fe_lock", t0, 48);

    // sync while checking: good count restarts, lock 2+4 frames after the sync
    do_reset();
    do_sync();
    run(16);
    do_align();
    run(32);
    chk("sync_chk_busy",    busy_o, 1'b1);
    chk("sync_chk_notlock", aligned_o[0], 1'b0);
    do_sync();
    t0 = -1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (aligned_o[0]) begin t0 = k; break; end
    end
    chk("sync_chk_lock", t0, 48);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
